// File: rtl/cm3_in_stage.sv
// Per-master AHB input stage: holds an address phase until the target output stage grants it.
// Optional held-transfer timeout with forced two-cycle ERROR: define CM3_IN_TIMEOUT_EN.
module cm3_in_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSELS,
   input  logic [31:0] HADDRS,
   input  logic [1:0]  HTRANSS,
   input  logic        HWRITES,
   input  logic [2:0]  HSIZES,
   input  logic [2:0]  HBURSTS,
   input  logic [3:0]  HPROTS,
   input  logic [3:0]  HMASTERS,
   input  logic        HMASTLOCKS,
   input  logic        HREADYS,
   input  logic        active_ip,
   input  logic        readyout_ip,
   input  logic [1:0]  resp_ip,
   output logic        sel_ip,
   output logic [31:0] addr_ip,
   output logic [1:0]  trans_ip,
   output logic        write_ip,
   output logic [2:0]  size_ip,
   output logic [2:0]  burst_ip,
   output logic [3:0]  prot_ip,
   output logic [3:0]  master_ip,
   output logic        mastlock_ip,
   output logic        held_tran_ip,
   output logic        HREADYOUTS,
   output logic [1:0]  HRESPS
);

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;

   generate
      if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
         $error("cm3_in_stage: TIMEOUT_CYCLES must be >= 2");
      end
   endgenerate

   typedef struct packed {
      logic        sel;
      logic [31:0] addr;
      logic [1:0]  trans;
      logic        write;
      logic [2:0]  size;
      logic [2:0]  burst;
      logic [3:0]  prot;
      logic [3:0]  master;
      logic        mastlock;
   } ahb_ctrl_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PEND,
      ST_DPH,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t    state;
   state_t    req_next;
   ahb_ctrl_t live;
   ahb_ctrl_t hold;
   ahb_ctrl_t out;
   logic      trans_valid;

   assign live = '{sel: HSELS, addr: HADDRS, trans: HTRANSS, write: HWRITES,
                   size: HSIZES, burst: HBURSTS, prot: HPROTS,
                   master: HMASTERS, mastlock: HMASTLOCKS};

   assign trans_valid = HSELS & HTRANSS[1] & HREADYS;
   // Next state for a new address phase (IDLE rules, reused after DPH and ERR2)
   assign req_next = trans_valid ? (active_ip ? ST_DPH : ST_PEND) : ST_IDLE;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) hold <= '0;
      else if (HREADYS) hold <= live;
   end

`ifdef CM3_IN_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] wait_cnt;

   // Zero outside PEND, so it reads 0 on the first PEND cycle
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) wait_cnt <= '0;
      else if (state == ST_PEND) wait_cnt <= wait_cnt + CNT_W'(1);
      else wait_cnt <= '0;
   end
`endif

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: state <= req_next;
            ST_PEND: begin
               if (active_ip) state <= ST_DPH;
`ifdef CM3_IN_TIMEOUT_EN
               else if (wait_cnt == CNT_LAST) state <= ST_ERR1;
`endif
            end
            ST_DPH:  if (readyout_ip) state <= req_next;
`ifdef CM3_IN_TIMEOUT_EN
            ST_ERR1: state <= ST_ERR2;
            ST_ERR2: state <= req_next;
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign out = (state == ST_PEND) ? hold : live;

   assign sel_ip      = out.sel;
   assign addr_ip     = out.addr;
   assign trans_ip    = out.trans;
   assign write_ip    = out.write;
   assign size_ip     = out.size;
   assign burst_ip    = out.burst;
   assign prot_ip     = out.prot;
   assign master_ip   = out.master;
   assign mastlock_ip = out.mastlock;

`ifdef CM3_IN_TIMEOUT_EN
   assign held_tran_ip = ((state == ST_PEND) | trans_valid) & (state != ST_ERR1);
`else
   assign held_tran_ip = (state == ST_PEND) | trans_valid;
`endif

   // Master-side response decode
   always_comb begin
      HREADYOUTS = 1'b1;
      HRESPS     = RESP_OKAY;
      case (state)
         ST_PEND: HREADYOUTS = 1'b0;
         ST_DPH: begin
            HREADYOUTS = readyout_ip;
            HRESPS     = resp_ip;
         end
`ifdef CM3_IN_TIMEOUT_EN
         ST_ERR1: begin
            HREADYOUTS = 1'b0;
            HRESPS     = RESP_ERROR;
         end
         ST_ERR2: HRESPS = RESP_ERROR;
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cm3_in_stage.sv
// Directed testbench for cm3_in_stage; master HREADY is looped back from HREADYOUTS.
// Timeout scenarios run when CM3_IN_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 4).
module tb_cm3_in_stage;

   logic        HCLK, HRESETn;
   logic        HSELS, HWRITES, HMASTLOCKS, HREADYS;
   logic [31:0] HADDRS;
   logic [1:0]  HTRANSS;
   logic [2:0]  HSIZES, HBURSTS;
   logic [3:0]  HPROTS, HMASTERS;
   logic        active_ip, readyout_ip;
   logic [1:0]  resp_ip;
   logic        sel_ip, write_ip, mastlock_ip, held_tran_ip, HREADYOUTS;
   logic [31:0] addr_ip;
   logic [1:0]  trans_ip, HRESPS;
   logic [2:0]  size_ip, burst_ip;
   logic [3:0]  prot_ip, master_ip;

   int n_checks = 0;
   int n_pass   = 0;

   assign HREADYS = HREADYOUTS;

   cm3_in_stage #(.TIMEOUT_CYCLES(4)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
      .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
      .HPROTS(HPROTS), .HMASTERS(HMASTERS), .HMASTLOCKS(HMASTLOCKS),
      .HREADYS(HREADYS), .active_ip(active_ip), .readyout_ip(readyout_ip),
      .resp_ip(resp_ip), .sel_ip(sel_ip), .addr_ip(addr_ip), .trans_ip(trans_ip),
      .write_ip(write_ip), .size_ip(size_ip), .burst_ip(burst_ip),
      .prot_ip(prot_ip), .master_ip(master_ip), .mastlock_ip(mastlock_ip),
      .held_tran_ip(held_tran_ip), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic settle();
      @(negedge HCLK);
   endtask

   initial begin
      HRESETn = 1'b0; HSELS = 1'b0; HADDRS = 32'h1234; HTRANSS = 2'b00;
      HWRITES = 1'b0; HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'h3;
      HMASTERS = 4'h1; HMASTLOCKS = 1'b0;
      active_ip = 1'b0; readyout_ip = 1'b1; resp_ip = 2'b00;
      settle();
      check("rst_ready", 32'(HREADYOUTS), 32'd1);
      check("rst_resp", 32'(HRESPS), 32'd0);
      check("rst_held", 32'(held_tran_ip), 32'd0);
      check("rst_addr_live", addr_ip, 32'h1234);
      tick(); HRESETn = 1'b1;

      // Uncontested transfer with two slave wait states
      HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h2000_0010; active_ip = 1'b1;
      settle();
      check("unc_held", 32'(held_tran_ip), 32'd1);
      check("unc_addr", addr_ip, 32'h2000_0010);
      check("unc_ready_addr", 32'(HREADYOUTS), 32'd1);
      tick(); HTRANSS = 2'b00; readyout_ip = 1'b0;
      settle();
      check("unc_wait1", 32'(HREADYOUTS), 32'd0);
      check("unc_wait1_held", 32'(held_tran_ip), 32'd0);
      tick(); settle();
      check("unc_wait2", 32'(HREADYOUTS), 32'd0);
      tick(); readyout_ip = 1'b1;
      settle();
      check("unc_done", 32'(HREADYOUTS), 32'd1);

      // Contended locked transfer: three held cycles
      tick(); HTRANSS = 2'b10; HADDRS = 32'h4000_0000; HMASTLOCKS = 1'b1; active_ip = 1'b0;
      settle();
      check("con_held0", 32'(held_tran_ip), 32'd1);
      check("con_ready0", 32'(HREADYOUTS), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick(); HADDRS = 32'h5555_0000 + 32'(i); HMASTLOCKS = 1'b0; active_ip = (i == 2);
         settle();
         check("con_wait", 32'(HREADYOUTS), 32'd0);
         check("con_addr_hold", addr_ip, 32'h4000_0000);
         check("con_held", 32'(held_tran_ip), 32'd1);
         check("con_lock_hold", 32'(mastlock_ip), 32'd1);
      end
      tick(); HTRANSS = 2'b00;
      settle();
      check("con_data_ready", 32'(HREADYOUTS), 32'd1);
      check("con_data_held", 32'(held_tran_ip), 32'd0);

      // INCR4 burst, always granted
      for (int i = 0; i < 4; i++) begin
         tick(); HTRANSS = (i == 0) ? 2'b10 : 2'b11; HADDRS = 32'h100 + 32'(4 * i);
         HBURSTS = 3'd3;
         settle();
         check("burst_ready", 32'(HREADYOUTS), 32'd1);
         check("burst_held", 32'(held_tran_ip), 32'd1);
         check("burst_addr", addr_ip, 32'h100 + 32'(4 * i));
         check("burst_type", 32'(burst_ip), 32'd3);
      end
      tick(); HTRANSS = 2'b00; HBURSTS = 3'd0;
      settle();
      check("burst_last_ready", 32'(HREADYOUTS), 32'd1);

      // Two-cycle slave ERROR, master cancels on second cycle
      tick(); HTRANSS = 2'b10; HADDRS = 32'h300;
      settle();
      tick(); HADDRS = 32'h304; resp_ip = 2'b01; readyout_ip = 1'b0;
      settle();
      check("err1_resp", 32'(HRESPS), 32'd1);
      check("err1_ready", 32'(HREADYOUTS), 32'd0);
      check("err1_held", 32'(held_tran_ip), 32'd0);
      tick(); HTRANSS = 2'b00; readyout_ip = 1'b1;
      settle();
      check("err2_resp", 32'(HRESPS), 32'd1);
      check("err2_ready", 32'(HREADYOUTS), 32'd1);
      check("err2_held", 32'(held_tran_ip), 32'd0);
      tick(); settle();
      check("err_idle_resp", 32'(HRESPS), 32'd0);
      check("err_idle_held", 32'(held_tran_ip), 32'd0);

      // Reset while a transfer is held
      tick(); resp_ip = 2'b00; HTRANSS = 2'b10; HADDRS = 32'h500; active_ip = 1'b0;
      settle();
      tick(); settle();
      check("rstp_pend_ready", 32'(HREADYOUTS), 32'd0);
      check("rstp_pend_held", 32'(held_tran_ip), 32'd1);
      HRESETn = 1'b0; HTRANSS = 2'b00; HADDRS = 32'h600;
      #1;
      check("rstp_ready", 32'(HREADYOUTS), 32'd1);
      check("rstp_held", 32'(held_tran_ip), 32'd0);
      check("rstp_addr_live", addr_ip, 32'h600);
      tick(); HRESETn = 1'b1;
      settle();
      check("rstp_after", 32'(HREADYOUTS), 32'd1);

      tick(); HTRANSS = 2'b10; HADDRS = 32'h700; active_ip = 1'b0;
      settle();
`ifdef CM3_IN_TIMEOUT_EN
      // Held past the terminal count: forced two-cycle ERROR
      for (int i = 0; i < 4; i++) begin
         tick(); settle();
         check("to_pend_ready", 32'(HREADYOUTS), 32'd0);
         check("to_pend_resp", 32'(HRESPS), 32'd0);
         check("to_pend_held", 32'(held_tran_ip), 32'd1);
      end
      tick(); settle();
      check("to_err1_ready", 32'(HREADYOUTS), 32'd0);
      check("to_err1_resp", 32'(HRESPS), 32'd1);
      check("to_err1_held", 32'(held_tran_ip), 32'd0);
      tick(); HTRANSS = 2'b00;
      settle();
      check("to_err2_ready", 32'(HREADYOUTS), 32'd1);
      check("to_err2_resp", 32'(HRESPS), 32'd1);
      tick(); settle();
      check("to_idle_resp", 32'(HRESPS), 32'd0);
      // Grant in the terminal-count cycle wins
      tick(); HTRANSS = 2'b10; active_ip = 1'b0;
      settle();
      for (int i = 0; i < 4; i++) begin
         tick(); active_ip = (i == 3);
         settle();
         check("tog_pend_ready", 32'(HREADYOUTS), 32'd0);
         check("tog_pend_resp", 32'(HRESPS), 32'd0);
      end
      tick(); HTRANSS = 2'b00;
      settle();
      check("tog_dph_ready", 32'(HREADYOUTS), 32'd1);
      check("tog_dph_resp", 32'(HRESPS), 32'd0);
`else
      // Without the timeout, PEND waits indefinitely
      for (int i = 0; i < 6; i++) begin
         tick(); settle();
         check("nto_pend_ready", 32'(HREADYOUTS), 32'd0);
         check("nto_pend_resp", 32'(HRESPS), 32'd0);
         check("nto_pend_held", 32'(held_tran_ip), 32'd1);
         check("nto_addr_hold", addr_ip, 32'h700);
      end
      tick(); active_ip = 1'b1;
      settle();
      check("nto_grant_ready", 32'(HREADYOUTS), 32'd0);
      tick(); HTRANSS = 2'b00;
      settle();
      check("nto_dph_ready", 32'(HREADYOUTS), 32'd1);
      check("nto_dph_resp", 32'(HRESPS), 32'd0);
`endif
      tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cm3_in_stage.md
Name: cm3_in_stage

Overview:
- Per-master input stage of the Cortex-M3 AHB bus matrix. It sits upstream of the output stages.
- It captures each master address phase and presents it to the target output stage, with held_tran_ip asserted.
- If the output stage has not granted the port (active_ip low), the stage holds the transfer and stalls the master until it is granted.
- During the data phase it returns the slave's HREADYOUT and HRESP to the master.

Parameters:
TIMEOUT_CYCLES, 256, max cycles a held transfer may wait before an ERROR is forced (only used with CM3_IN_TIMEOUT_EN; must be >= 2)

Ports:
HCLK  in  1  AHB clock, rising edge
HRESETn  in  1  async active-low reset
HSELS  in  1  master-side select for this matrix
HADDRS  in  32  master address
HTRANSS  in  2  master transfer type
HWRITES  in  1  master direction
HSIZES  in  3  master size
HBURSTS  in  3  master burst
HPROTS  in  4  master protection
HMASTERS  in  4  master ID
HMASTLOCKS  in  1  master lock
HREADYS  in  1  master-side HREADY (address phase sample enable)
active_ip  in  1  grant from target output stage
readyout_ip  in  1  data-phase HREADY from target output stage
resp_ip  in  2  data-phase HRESP from target slave
sel_ip  out  1  select to output stage
addr_ip  out  32  address to output stage
trans_ip  out  2  transfer type to output stage
write_ip  out  1  direction to output stage
size_ip  out  3  size to output stage
burst_ip  out  3  burst to output stage
prot_ip  out  4  protection to output stage
master_ip  out  4  master ID to output stage
mastlock_ip  out  1  lock to output stage
held_tran_ip  out  1  transfer request pending to output stage
HREADYOUTS  out  1  HREADY to master
HRESPS  out  2  response to master (OKAY=00, ERROR=01)

Behaviour:
- Clock HCLK. Reset HRESETn, asynchronous, active-low.
- Reset values:
  - state = IDLE; all hold registers = 0.
  - HREADYOUTS = 1, HRESPS = 00, held_tran_ip = 0.
  - All *_ip outputs show live inputs.
- trans_valid = HSELS & HTRANSS[1] & HREADYS.
- IDLE and BUSY transfers, and unselected transfers, are never held. They get a zero-wait OKAY.
- Hold register loads all address/control inputs on every cycle with HREADYS = 1.
- State machine (IDLE, PEND, DPH; ERR1, ERR2 only with the optional feature):
  - IDLE:
    - HREADYOUTS = 1, HRESPS = OKAY.
    - trans_valid & active_ip goes to DPH. trans_valid & ~active_ip goes to PEND.
  - PEND:
    - *_ip outputs come from the hold register; held_tran_ip = 1.
    - HREADYOUTS = 0, HRESPS = OKAY.
    - active_ip goes to DPH; otherwise stay in PEND.
  - DPH:
    - HREADYOUTS = readyout_ip, HRESPS = resp_ip.
    - While readyout_ip = 0, stay in DPH. No sampling occurs because HREADYS is low.
    - When readyout_ip = 1, take the next state using the IDLE rules, which gives back-to-back transfers with zero bubble.
- Output mux:
  - In PEND, *_ip outputs come from the hold register; otherwise they come from the live inputs.
  - held_tran_ip = (state == PEND) | trans_valid.
- A transfer accepted in the same cycle it is issued adds no latency. Each held cycle adds exactly one master wait state.
- Two-cycle ERROR from the slave passes straight through resp_ip/readyout_ip. If the master cancels with IDLE on the second cycle, nothing is held.
- A locked sequence keeps mastlock_ip asserted from the hold register while in PEND.
- Reset mid-transfer: return to IDLE at once and drop any held transfer.

Optional Feature:
- Macro: CM3_IN_TIMEOUT_EN.
- With the macro defined:
  - A wait counter clears on entry to PEND and increments each PEND cycle.
  - If the count reaches TIMEOUT_CYCLES-1 while active_ip = 0, go to ERR1.
    - ERR1: HREADYOUTS = 0, HRESPS = 01, held_tran_ip = 0, held transfer dropped.
    - ERR2: HREADYOUTS = 1, HRESPS = 01.
    - From ERR2, take the next state using the IDLE rules.
  - active_ip in the terminal-count cycle wins: go to DPH, no error.
- Without the macro: no counter and no ERR states. PEND waits indefinitely.

Test Plan:
- Uncontested transfer:
  - Stimulus: HSELS=1, HTRANSS=NONSEQ, HADDRS=0x2000_0010, active_ip=1.
  - Response: held_tran_ip=1 in the same cycle, addr_ip=0x2000_0010, state DPH next cycle. readyout_ip=0 for 2 cycles gives HREADYOUTS=0 for those 2 cycles.
- Contended transfer:
  - Stimulus: NONSEQ to 0x4000_0000 with active_ip=0 for 3 cycles.
  - Response: HREADYOUTS=0 for 3 cycles. addr_ip holds 0x4000_0000 even though HADDRS changes. Accepted on the 4th cycle.
- Burst:
  - Stimulus: INCR4 burst, active_ip=1 throughout, readyout_ip=1.
  - Response: 4 consecutive DPH cycles, HREADYOUTS=1 every cycle, no PEND entry.
- Slave ERROR:
  - Stimulus: resp_ip=01 with readyout_ip 0 then 1; master drives IDLE on the second cycle.
  - Response: HRESPS=01 for both cycles; state goes to IDLE with held_tran_ip=0.
- Reset while held:
  - Stimulus: assert HRESETn=0 while in PEND.
  - Response: immediately HREADYOUTS=1, held_tran_ip=0, state IDLE.
- With CM3_IN_TIMEOUT_EN and TIMEOUT_CYCLES=4, active_ip held 0:
  - Response: PEND for 4 cycles, then ERR1 (HREADYOUTS=0, HRESPS=01), then ERR2 (HREADYOUTS=1, HRESPS=01).
  - Repeat with active_ip=1 in the 4th cycle: goes to DPH, no error.
